// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset value, hold, redirect load or +4 advance.
module pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] load_value,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // pc+4 wraps naturally modulo 2^32
  always_comb pc_plus4 = pc + 32'd4;

  // Load has priority over advance; neither means hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (advance) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: FSM, PC, IF/ID latch and delivered-instruction counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  // Depth of the attached memory; only imem_addr[IMEM_AW-1:0] is decoded there,
  // so fetch wraps every 2^(IMEM_AW+2) bytes by design.
  parameter int unsigned IMEM_AW  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic         do_redirect;
  logic         do_squash;
  logic         do_fetch;
  logic [31:0]  pc_plus4;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: HALT is only left through reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt)  state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Per-edge actions in RUN: redirect > halt > stall > fetch
  always_comb begin
    do_redirect = 1'b0;
    do_squash   = 1'b0;
    do_fetch    = 1'b0;
    if (state_q == RUN) begin
      do_redirect = redirect;
      do_squash   = redirect || halt;
      do_fetch    = !redirect && !halt && !stall;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (do_redirect),
    .advance    (do_fetch),
    .load_value ({redirect_target[31:2], 2'b00}),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  // Word address for the combinational-read instruction memory
  always_comb imem_addr = {2'b00, pc[31:2]};

  // IF/ID latch, misalignment pulse and delivered-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_instr  <= NOP;
      if_id_npc    <= '0;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      misalign_err <= do_redirect && (redirect_target[1:0] != 2'b00);
      if (do_squash) begin
        if_id_instr <= NOP;
        if_id_valid <= 1'b0;
      end else if (do_fetch) begin
        if_id_instr <= imem_data;
        if_id_npc   <= pc_plus4;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized run
// against a behavioural reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [128];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (mode: 0 idle, 1 fetching, 2 stopped)
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_npc, m_count;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  always_comb imem_data = mem[imem_addr[6:0]];

  fetch_ctrl #(
    .RESET_PC (RST_PC),
    .IMEM_AW  (7)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_npc       (if_id_npc),
    .if_id_valid     (if_id_valid),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  // Model of one rising edge, written from the behavioural rules
  task automatic model_step(input bit s, input bit st, input bit rd,
                            input logic [31:0] tg, input bit h, input bit r);
    if (r) begin
      m_mode = 0; m_pc = RST_PC; m_instr = 0; m_npc = 0;
      m_valid = 0; m_mis = 0; m_count = 0;
    end else begin
      m_mis = 0;
      if (m_mode == 0) begin
        if (s) m_mode = 1;
      end else if (m_mode == 1) begin
        if (rd) begin
          m_pc = tg - (tg % 4);
          m_instr = 0; m_valid = 0;
          m_mis = (tg % 4) != 0;
          if (h) m_mode = 2;
        end else if (h) begin
          m_instr = 0; m_valid = 0; m_mode = 2;
        end else if (!st) begin
          m_instr = mem[(m_pc / 4) % 128];
          m_npc   = m_pc + 4;
          m_valid = 1;
          m_pc    = m_pc + 4;
          m_count = m_count + 1;
        end
      end
    end
  endtask

  // Drive inputs away from the edge, take one edge, then settle for sampling
  task automatic cycle(input bit s, input bit st, input bit rd,
                       input logic [31:0] tg, input bit h, input bit r);
    start = s; stall = st; redirect = rd; redirect_target = tg; halt = h; rst_n = !r;
    @(posedge clk);
    model_step(s, st, rd, tg, h, r);
    #1;
  endtask

  task automatic restart(input int n_fetch);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n_fetch; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic preload();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'h002300aa;
    mem[1] = 32'h10254321;
    mem[2] = 32'h00200022;
    mem[3] = 32'h8c123456;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0, 1);
    n_checks++; if (pc !== RST_PC) begin n_errors++; $display("FAIL reset_pc got %h exp %h", pc, RST_PC); end
    n_checks++; if (imem_addr !== (RST_PC >> 2)) begin n_errors++; $display("FAIL reset_imem_addr got %h exp %h", imem_addr, RST_PC >> 2); end
    n_checks++; if (if_id_instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
    n_checks++; if (if_id_npc !== 32'h0) begin n_errors++; $display("FAIL reset_npc got %h exp 0", if_id_npc); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    n_checks++; if (misalign_err !== 1'b0) begin n_errors++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
    n_checks++; if (fetch_count !== 32'h0) begin n_errors++; $display("FAIL reset_count got %h exp 0", fetch_count); end
    // Idle: no fetch without start even with stall/redirect toggling
    cycle(0, 0, 1, 32'h40, 0, 0);
    n_checks++; if (pc !== RST_PC || if_id_valid !== 1'b0) begin n_errors++; $display("FAIL idle_hold got pc %h valid %b exp pc %h valid 0", pc, if_id_valid, RST_PC); end
  endtask

  task automatic test_start_fetch();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h002300aa; exp_i[1] = 32'h10254321; exp_i[2] = 32'h00200022;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL start_first_valid got %b exp 0", if_id_valid); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++; if (if_id_instr !== exp_i[i] || if_id_valid !== 1'b1) begin
        n_errors++; $display("FAIL start_instr%0d got %h/%b exp %h/1", i, if_id_instr, if_id_valid, exp_i[i]); end
      n_checks++; if (if_id_npc !== 32'(4 * (i + 1))) begin
        n_errors++; $display("FAIL start_npc%0d got %h exp %h", i, if_id_npc, 32'(4 * (i + 1))); end
    end
    n_checks++; if (fetch_count !== 32'd3) begin n_errors++; $display("FAIL start_count got %0d exp 3", fetch_count); end
  endtask

  task automatic test_stall();
    restart(2);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      n_checks++; if (pc !== 32'h8 || if_id_instr !== 32'h10254321) begin
        n_errors++; $display("FAIL stall_hold%0d got pc %h instr %h exp pc 8 instr 10254321", i, pc, if_id_instr); end
      n_checks++; if (fetch_count !== 32'd2) begin n_errors++; $display("FAIL stall_count%0d got %0d exp 2", i, fetch_count); end
    end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (if_id_instr !== 32'h00200022 || fetch_count !== 32'd3) begin
      n_errors++; $display("FAIL stall_resume got instr %h count %0d exp 00200022 3", if_id_instr, fetch_count); end
  endtask

  task automatic test_redirect();
    restart(2);
    cycle(0, 0, 1, 32'h14, 0, 0);
    n_checks++; if (if_id_valid !== 1'b0 || pc !== 32'h14 || if_id_instr !== 32'h0) begin
      n_errors++; $display("FAIL redir_bubble got valid %b pc %h instr %h exp 0 14 0", if_id_valid, pc, if_id_instr); end
    n_checks++; if (misalign_err !== 1'b0) begin n_errors++; $display("FAIL redir_aligned_err got %b exp 0", misalign_err); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (if_id_instr !== mem[5] || if_id_npc !== 32'h18 || if_id_valid !== 1'b1) begin
      n_errors++; $display("FAIL redir_target got %h/%h/%b exp %h/18/1", if_id_instr, if_id_npc, if_id_valid, mem[5]); end
  endtask

  task automatic test_redirect_stall();
    restart(2);
    cycle(0, 1, 1, 32'h1F, 0, 0);
    n_checks++; if (pc !== 32'h1C || if_id_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstall_pc got pc %h valid %b exp 1c 0", pc, if_id_valid); end
    n_checks++; if (misalign_err !== 1'b1) begin n_errors++; $display("FAIL rstall_mis got %b exp 1", misalign_err); end
    cycle(0, 1, 0, 0, 0, 0);
    n_checks++; if (misalign_err !== 1'b0 || pc !== 32'h1C) begin
      n_errors++; $display("FAIL rstall_pulse got mis %b pc %h exp 0 1c", misalign_err, pc); end
  endtask

  task automatic test_halt();
    logic [31:0] tg;
    restart(3);
    cycle(0, 0, 0, 0, 1, 0);
    n_checks++; if (if_id_valid !== 1'b0 || pc !== 32'hC) begin
      n_errors++; $display("FAIL halt_enter got valid %b pc %h exp 0 c", if_id_valid, pc); end
    for (int i = 0; i < 10; i++) begin
      tg = $urandom;
      cycle(1, 1'($urandom), 1'($urandom), tg, 0, 0);
      n_checks++; if (pc !== 32'hC || if_id_valid !== 1'b0 || fetch_count !== 32'd3 || misalign_err !== 1'b0) begin
        n_errors++; $display("FAIL halt_frozen%0d got pc %h valid %b cnt %0d mis %b exp c 0 3 0", i, pc, if_id_valid, fetch_count, misalign_err); end
    end
  endtask

  task automatic test_reset_mid_run();
    restart(3);
    cycle(0, 1, 1, 32'h43, 0, 1);
    n_checks++; if (pc !== RST_PC || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_npc !== 32'h0
                    || misalign_err !== 1'b0 || fetch_count !== 32'h0) begin
      n_errors++; $display("FAIL midrst got pc %h v %b i %h n %h m %b c %0d exp all reset",
                           pc, if_id_valid, if_id_instr, if_id_npc, misalign_err, fetch_count); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (if_id_valid !== 1'b0 || pc !== RST_PC) begin
      n_errors++; $display("FAIL midrst_idle got valid %b pc %h exp 0 %h", if_id_valid, pc, RST_PC); end
  endtask

  task automatic test_wrap();
    restart(1);
    cycle(0, 0, 1, 32'h1FC, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'h200 || imem_addr[6:0] !== 7'd0) begin
      n_errors++; $display("FAIL wrap_pc got pc %h idx %h exp 200 0", pc, imem_addr[6:0]); end
    n_checks++; if (if_id_instr !== mem[127]) begin n_errors++; $display("FAIL wrap_last got %h exp %h", if_id_instr, mem[127]); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (if_id_instr !== 32'h002300aa || if_id_npc !== 32'h204) begin
      n_errors++; $display("FAIL wrap_word0 got %h/%h exp 002300aa/204", if_id_instr, if_id_npc); end
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'h0 || if_id_npc !== 32'h0) begin
      n_errors++; $display("FAIL wrap_32 got pc %h npc %h exp 0 0", pc, if_id_npc); end
  endtask

  task automatic test_random();
    bit s, st, rd, h, r;
    logic [31:0] tg;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    cycle(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom % 60) == 0;
      s  = ($urandom % 6) == 0;
      h  = ($urandom % 50) == 0;
      rd = ($urandom % 7) == 0;
      st = ($urandom % 4) == 0;
      tg = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'h3FF);
      cycle(s, st, rd, tg, h, r);
      n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc@%0d got %h exp %h", n, pc, m_pc); end
      n_checks++; if (imem_addr !== {2'b00, m_pc[31:2]}) begin n_errors++; $display("FAIL rnd_addr@%0d got %h exp %h", n, imem_addr, m_pc / 4); end
      n_checks++; if (if_id_instr !== m_instr) begin n_errors++; $display("FAIL rnd_instr@%0d got %h exp %h", n, if_id_instr, m_instr); end
      n_checks++; if (if_id_npc !== m_npc) begin n_errors++; $display("FAIL rnd_npc@%0d got %h exp %h", n, if_id_npc, m_npc); end
      n_checks++; if (if_id_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid@%0d got %b exp %b", n, if_id_valid, m_valid); end
      n_checks++; if (misalign_err !== m_mis) begin n_errors++; $display("FAIL rnd_mis@%0d got %b exp %b", n, misalign_err, m_mis); end
      n_checks++; if (fetch_count !== m_count) begin n_errors++; $display("FAIL rnd_count@%0d got %0d exp %0d", n, fetch_count, m_count); end
    end
  endtask

  initial begin
    preload();
    #2;
    test_reset();
    test_start_fetch();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_reset_mid_run();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
